// File: rtl/lif_array_tdm.sv
// Time-multiplexed array of leaky integrate-and-fire neurons.
// One shared update datapath visits neurons round-robin on enabled cycles.
module lif_array_tdm #(
    parameter int N_NEURONS = 4,
    parameter int WIDTH     = 8,
    parameter int REFRAC_W  = 4,
    localparam int IDX_W    = $clog2(N_NEURONS)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       enable,
    input  logic [N_NEURONS*WIDTH-1:0] currents,
    input  logic [WIDTH-1:0]           cfg_threshold,
    input  logic [2:0]                 cfg_leak_shift,
    input  logic                       cfg_reset_mode,
    input  logic [REFRAC_W-1:0]        cfg_refrac,
    input  logic [IDX_W-1:0]           rd_idx,
    output logic [WIDTH-1:0]           rd_state,
    output logic                       spike_valid,
    output logic [IDX_W-1:0]           spike_idx,
    output logic [N_NEURONS-1:0]       spike_vec,
    output logic                       frame_done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);
    localparam logic [IDX_W:0]   N_L      = (IDX_W + 1)'(N_NEURONS);

    logic [WIDTH-1:0]     state_q  [N_NEURONS];
    logic [WIDTH-1:0]     state_d  [N_NEURONS];
    logic [REFRAC_W-1:0]  refrac_q [N_NEURONS];
    logic [REFRAC_W-1:0]  refrac_d [N_NEURONS];
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [N_NEURONS-1:0] acc_q, acc_d;
    logic [N_NEURONS-1:0] spike_vec_q, spike_vec_d;
    logic [WIDTH-1:0]     thr_q, thr_d;
    logic [2:0]           shift_q, shift_d;
    logic                 mode_q, mode_d;
    logic [REFRAC_W-1:0]  rfr_q, rfr_d;
    logic [WIDTH-1:0]     rd_state_q, rd_state_d;
    logic                 spike_valid_q, spike_valid_d;
    logic [IDX_W-1:0]     spike_idx_q, spike_idx_d;
    logic                 frame_done_q, frame_done_d;

    logic                 first, last, in_refrac, spike;
    logic [WIDTH-1:0]     thr_e, cur, s_cur, v;
    logic [2:0]           shift_e;
    logic                 mode_e;
    logic [REFRAC_W-1:0]  rfr_e;
    logic [WIDTH:0]       sum;
    logic [N_NEURONS-1:0] hit;

    // Sweep-start update sees the incoming config, later ones the shadow copy.
    always_comb begin
        first   = (idx_q == '0);
        last    = (idx_q == LAST_IDX);
        thr_e   = first ? cfg_threshold  : thr_q;
        shift_e = first ? cfg_leak_shift : shift_q;
        mode_e  = first ? cfg_reset_mode : mode_q;
        rfr_e   = first ? cfg_refrac     : rfr_q;

        cur       = currents[idx_q*WIDTH +: WIDTH];
        s_cur     = state_q[idx_q];
        in_refrac = (refrac_q[idx_q] != '0);
        sum       = {1'b0, cur} + {1'b0, s_cur >> shift_e};
        v         = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
        spike     = !in_refrac && (v >= thr_e);
        hit       = spike ? ({{(N_NEURONS-1){1'b0}}, 1'b1} << idx_q) : '0;
    end

    always_comb begin
        for (int k = 0; k < N_NEURONS; k++) begin
            state_d[k]  = state_q[k];
            refrac_d[k] = refrac_q[k];
        end
        idx_d         = idx_q;
        acc_d         = acc_q;
        spike_vec_d   = spike_vec_q;
        thr_d         = thr_q;
        shift_d       = shift_q;
        mode_d        = mode_q;
        rfr_d         = rfr_q;
        spike_valid_d = 1'b0;
        spike_idx_d   = spike_idx_q;
        frame_done_d  = 1'b0;

        if ({1'b0, rd_idx} < N_L)
            rd_state_d = state_q[rd_idx];
        else
            rd_state_d = '0;

        if (enable) begin
            idx_d = last ? '0 : idx_q + 1'b1;
            if (first) begin
                thr_d   = cfg_threshold;
                shift_d = cfg_leak_shift;
                mode_d  = cfg_reset_mode;
                rfr_d   = cfg_refrac;
            end
            if (in_refrac) begin
                refrac_d[idx_q] = refrac_q[idx_q] - 1'b1;
            end else if (spike) begin
                state_d[idx_q]  = mode_e ? v - thr_e : '0;
                refrac_d[idx_q] = rfr_e;
            end else begin
                state_d[idx_q] = v;
            end
            spike_valid_d = spike;
            if (spike)
                spike_idx_d = idx_q;
            if (last) begin
                spike_vec_d  = acc_q | hit;
                acc_d        = '0;
                frame_done_d = 1'b1;
            end else begin
                acc_d = acc_q | hit;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int k = 0; k < N_NEURONS; k++) begin
                state_q[k]  <= '0;
                refrac_q[k] <= '0;
            end
            idx_q         <= '0;
            acc_q         <= '0;
            spike_vec_q   <= '0;
            thr_q         <= '1;
            shift_q       <= 3'd1;
            mode_q        <= 1'b0;
            rfr_q         <= '0;
            rd_state_q    <= '0;
            spike_valid_q <= 1'b0;
            spike_idx_q   <= '0;
            frame_done_q  <= 1'b0;
        end else begin
            for (int k = 0; k < N_NEURONS; k++) begin
                state_q[k]  <= state_d[k];
                refrac_q[k] <= refrac_d[k];
            end
            idx_q         <= idx_d;
            acc_q         <= acc_d;
            spike_vec_q   <= spike_vec_d;
            thr_q         <= thr_d;
            shift_q       <= shift_d;
            mode_q        <= mode_d;
            rfr_q         <= rfr_d;
            rd_state_q    <= rd_state_d;
            spike_valid_q <= spike_valid_d;
            spike_idx_q   <= spike_idx_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign rd_state    = rd_state_q;
    assign spike_valid = spike_valid_q;
    assign spike_idx   = spike_idx_q;
    assign spike_vec   = spike_vec_q;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_lif_array_tdm.sv
// Directed bench for lif_array_tdm with hand-computed expectations.
// Inputs change 1ns after each rising edge; outputs are sampled there too.
module tb_lif_array_tdm;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [31:0] currents;
    logic [7:0]  cfg_threshold;
    logic [2:0]  cfg_leak_shift;
    logic        cfg_reset_mode;
    logic [3:0]  cfg_refrac;
    logic [1:0]  rd_idx;
    logic [7:0]  rd_state;
    logic        spike_valid;
    logic [1:0]  spike_idx;
    logic [3:0]  spike_vec;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    lif_array_tdm #(
        .N_NEURONS(4),
        .WIDTH(8),
        .REFRAC_W(4)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .enable(enable),
        .currents(currents),
        .cfg_threshold(cfg_threshold),
        .cfg_leak_shift(cfg_leak_shift),
        .cfg_reset_mode(cfg_reset_mode),
        .cfg_refrac(cfg_refrac),
        .rd_idx(rd_idx),
        .rd_state(rd_state),
        .spike_valid(spike_valid),
        .spike_idx(spike_idx),
        .spike_vec(spike_vec),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    int exp1 [9] = '{100, 150, 175, 187, 193, 196, 198, 199, 199};
    int exp2 [6] = '{101, 151, 176, 189, 195, 198};

    initial begin
        reset_n        = 1'b0;
        enable         = 1'b0;
        currents       = '0;
        cfg_threshold  = 8'd200;
        cfg_leak_shift = 3'd1;
        cfg_reset_mode = 1'b0;
        cfg_refrac     = 4'd0;
        rd_idx         = 2'd0;
        tick();
        tick();
        chk("rst_rd_state", rd_state, 0);
        chk("rst_spike_valid", spike_valid, 0);
        chk("rst_spike_idx", spike_idx, 0);
        chk("rst_spike_vec", spike_vec, 0);
        chk("rst_frame_done", frame_done, 0);

        // Leaky integration converging below threshold
        reset_n  = 1'b1;
        enable   = 1'b1;
        currents = {8'd0, 8'd0, 8'd0, 8'd100};
        for (int s = 0; s < 9; s++) begin
            for (int k = 0; k < 4; k++) begin
                tick();
                chk("t1_no_spike", spike_valid, 0);
                if (k == 1) chk("t1_state", rd_state, exp1[s]);
                if (k == 3) chk("t1_frame_done", frame_done, 1);
                if (k == 3) chk("t1_vec", spike_vec, 0);
            end
        end

        // Reaches threshold on the 7th update
        do_reset();
        currents = {8'd0, 8'd0, 8'd0, 8'd101};
        for (int s = 0; s < 6; s++) begin
            for (int k = 0; k < 4; k++) begin
                tick();
                chk("t2_no_spike", spike_valid, 0);
                if (k == 1) chk("t2_state", rd_state, exp2[s]);
            end
        end
        tick();
        chk("t2_spike", spike_valid, 1);
        chk("t2_spike_idx", spike_idx, 0);
        chk("t2_fd_mid", frame_done, 0);
        tick();
        chk("t2_state0", rd_state, 0);
        chk("t2_pulse", spike_valid, 0);
        tick();
        tick();
        chk("t2_fd", frame_done, 1);
        chk("t2_vec", spike_vec, 4'b0001);
        for (int k = 0; k < 4; k++) tick();
        chk("t2_vec_clr", spike_vec, 0);

        // Saturation, subtract mode exposes the clamped value
        enable         = 1'b0;
        cfg_threshold  = 8'd250;
        cfg_leak_shift = 3'd0;
        cfg_reset_mode = 1'b1;
        do_reset();
        enable   = 1'b1;
        rd_idx   = 2'd1;
        currents = {8'd0, 8'd0, 8'd200, 8'd255};
        tick();
        chk("t3_sat_spike0", spike_valid, 1);
        chk("t3_sat_idx0", spike_idx, 0);
        tick();
        chk("t3_no_spike1", spike_valid, 0);
        tick();
        chk("t3_state1a", rd_state, 200);
        tick();
        chk("t3_vec1", spike_vec, 4'b0001);
        chk("t3_fd1", frame_done, 1);
        tick();
        tick();
        chk("t3_spike1", spike_valid, 1);
        chk("t3_idx1", spike_idx, 1);
        tick();
        chk("t3_state1b", rd_state, 5);
        tick();
        chk("t3_vec2", spike_vec, 4'b0011);

        // Refractory hold for two updates
        enable         = 1'b0;
        cfg_threshold  = 8'd200;
        cfg_leak_shift = 3'd1;
        cfg_reset_mode = 1'b0;
        cfg_refrac     = 4'd2;
        do_reset();
        enable   = 1'b1;
        rd_idx   = 2'd2;
        currents = {8'd0, 8'd255, 8'd0, 8'd0};
        for (int s = 0; s < 4; s++) begin
            tick();
            tick();
            tick();
            chk("t4_spike", spike_valid, (s == 0 || s == 3) ? 1 : 0);
            tick();
            chk("t4_state", rd_state, 0);
            chk("t4_vec", spike_vec, (s == 0 || s == 3) ? 4 : 0);
        end

        // Subtract mode: 120 then 170 + 60 = 230 -> 30
        enable         = 1'b0;
        cfg_reset_mode = 1'b1;
        cfg_refrac     = 4'd0;
        do_reset();
        enable   = 1'b1;
        rd_idx   = 2'd3;
        currents = {8'd120, 8'd0, 8'd0, 8'd0};
        for (int k = 0; k < 4; k++) tick();
        chk("t5_no_spike", spike_valid, 0);
        tick();
        chk("t5_state120", rd_state, 120);
        currents = {8'd170, 8'd0, 8'd0, 8'd0};
        tick();
        tick();
        tick();
        chk("t5_spike", spike_valid, 1);
        chk("t5_idx", spike_idx, 3);
        chk("t5_fd", frame_done, 1);
        chk("t5_vec", spike_vec, 4'b1000);
        tick();
        chk("t5_state30", rd_state, 30);

        // Enable low mid-sweep: nothing moves
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t6_sv_low", spike_valid, 0);
            chk("t6_fd_low", frame_done, 0);
            chk("t6_hold", rd_state, 30);
            chk("t6_vec_hold", spike_vec, 4'b1000);
        end

        // Reset at idx 2, then fresh config at neuron 0
        enable = 1'b1;
        tick();
        chk("t6_resume", spike_valid, 0);
        reset_n = 1'b0;
        tick();
        chk("t7_rd_state", rd_state, 0);
        chk("t7_sv", spike_valid, 0);
        chk("t7_vec", spike_vec, 0);
        chk("t7_fd", frame_done, 0);
        chk("t7_idx", spike_idx, 0);
        reset_n        = 1'b1;
        cfg_threshold  = 8'd50;
        cfg_reset_mode = 1'b0;
        currents       = {8'd0, 8'd0, 8'd60, 8'd60};
        tick();
        chk("t7_n0_spike", spike_valid, 1);
        chk("t7_n0_idx", spike_idx, 0);
        cfg_threshold = 8'd255;
        tick();
        chk("t7_latched_spike", spike_valid, 1);
        chk("t7_latched_idx", spike_idx, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
